// File: rtl/fsm_input_pkg.sv
// Shared types and command codes for the push-button input conditioner.
package fsm_input_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHORD   = 2'd1,
        EMIT    = 2'd2,
        RELEASE = 2'd3
    } cond_state_t;

    localparam logic [1:0] CODE_IDLE = 2'b00;
    localparam logic [1:0] CODE_B1   = 2'b10;
    localparam logic [1:0] CODE_B2   = 2'b01;
    localparam logic [1:0] CODE_BOTH = 2'b11;

endpackage

// File: rtl/input_debounce.sv
// One button line: 2-flop synchroniser followed by a counting debouncer.
module input_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Level flips only after the synced line disagrees for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fsm_input_conditioner.sv
// Debounces two buttons, merges chords and emits one-cycle command codes.
// Optional autorepeat while held: define FSM_COND_AUTOREPEAT_EN.
module fsm_input_conditioner
    import fsm_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CHORD_CYCLES    = 4,
    parameter int unsigned REPEAT_CYCLES   = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn1_raw,
    input  logic btn2_raw,
    output logic input1,
    output logic input2,
    output logic cmd_valid,
    output logic busy
);

    localparam int unsigned TIMER_W = (CHORD_CYCLES > 1) ? $clog2(CHORD_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CHORD_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (CHORD_CYCLES < 1) begin : g_bad_chord
        $error("CHORD_CYCLES must be at least 1");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be at least 2");
    end

    logic db1;
    logic db2;
    logic [1:0] db;

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn1_raw),
        .level   (db1)
    );

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_raw (btn2_raw),
        .level   (db2)
    );

    assign db = (db1 ? CODE_B1 : CODE_IDLE) | (db2 ? CODE_B2 : CODE_IDLE);

    cond_state_t        state;
    cond_state_t        state_next;
    logic [1:0]         code;
    logic [1:0]         code_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_next;
    logic [1:0]         cmd;
    logic [1:0]         cmd_next;

`ifdef FSM_COND_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt;
    logic [RPT_W-1:0] rpt_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt <= '0;
        end else begin
            rpt <= rpt_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            code      <= CODE_IDLE;
            timer     <= '0;
            cmd       <= CODE_IDLE;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            code      <= code_next;
            timer     <= timer_next;
            cmd       <= cmd_next;
            cmd_valid <= (cmd_next != CODE_IDLE);
            busy      <= (state_next != IDLE);
        end
    end

    // Next-state logic; cmd_next is non-zero only on edges that enter EMIT.
    always_comb begin
        state_next = state;
        code_next  = code;
        timer_next = timer;
        cmd_next   = CODE_IDLE;
`ifdef FSM_COND_AUTOREPEAT_EN
        rpt_next   = rpt;
`endif
        case (state)
            IDLE: begin
                if (db != CODE_IDLE) begin
                    code_next  = db;
                    timer_next = '0;
                    state_next = CHORD;
                end
            end
            CHORD: begin
                code_next = (code | db) & CODE_BOTH;
                if (timer == TIMER_LAST) begin
                    cmd_next   = code_next;
                    state_next = EMIT;
`ifdef FSM_COND_AUTOREPEAT_EN
                    rpt_next   = '0;
`endif
                end else begin
                    timer_next = timer + TIMER_W'(1);
                end
            end
            EMIT: begin
                state_next = RELEASE;
`ifdef FSM_COND_AUTOREPEAT_EN
                rpt_next   = rpt + RPT_W'(1);
`endif
            end
            RELEASE: begin
                if (db == CODE_IDLE) begin
                    state_next = IDLE;
                end
`ifdef FSM_COND_AUTOREPEAT_EN
                // Repeat period counts from the emitting edge; any change of db restarts it.
                else if (db == code) begin
                    if (rpt == RPT_LAST) begin
                        cmd_next   = code;
                        rpt_next   = '0;
                        state_next = EMIT;
                    end else begin
                        rpt_next = rpt + RPT_W'(1);
                    end
                end else begin
                    rpt_next = '0;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign input1 = cmd[1];
    assign input2 = cmd[0];

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Directed-vector bench for fsm_input_conditioner (DEBOUNCE=4, CHORD=2, REPEAT=10).
module tb_fsm_input_conditioner;

    logic clk;
    logic reset_n;
    logic btn1_raw;
    logic btn2_raw;
    logic input1;
    logic input2;
    logic cmd_valid;
    logic busy;

    int checks = 0;
    int passed = 0;

    fsm_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CHORD_CYCLES    (2),
        .REPEAT_CYCLES   (10)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn1_raw  (btn1_raw),
        .btn2_raw  (btn2_raw),
        .input1    (input1),
        .input2    (input2),
        .cmd_valid (cmd_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one edge; return at the following falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL %s idle timeout busy=%b", name, busy);
        else passed++;
        tick();
        tick();
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        btn1_raw = 1'b0;
        btn2_raw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({input1, input2, cmd_valid, busy} !== 4'b0000)
                $display("FAIL reset k=%0d out=%b exp=0000", k, {input1, input2, cmd_valid, busy});
            else passed++;
        end
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({input1, input2, cmd_valid, busy} !== 4'b0000)
            $display("FAIL post_reset out=%b exp=0000", {input1, input2, cmd_valid, busy});
        else passed++;
    endtask

    task automatic test_single_press;
        logic [2:0] exp;
        btn1_raw = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            tick();
            exp = (k == 8) ? 3'b101 : 3'b000;
            checks++;
            if ({input1, input2, cmd_valid} !== exp)
                $display("FAIL press k=%0d cmd=%b exp=%b", k, {input1, input2, cmd_valid}, exp);
            else passed++;
            checks++;
            if (busy !== (k >= 6))
                $display("FAIL press_busy k=%0d busy=%b exp=%b", k, busy, (k >= 6));
            else passed++;
        end
        btn1_raw = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            tick();
            checks++;
            if ({input1, input2, cmd_valid, busy} !== {3'b000, (k <= 5)})
                $display("FAIL release k=%0d out=%b exp=%b", k, {input1, input2, cmd_valid, busy},
                         {3'b000, (k <= 5)});
            else passed++;
        end
    endtask

    task automatic test_glitch;
        btn1_raw = 1'b1;
        tick();
        tick();
        tick();
        btn1_raw = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++;
            if ({input1, input2, cmd_valid, busy} !== 4'b0000)
                $display("FAIL glitch k=%0d out=%b exp=0000", k, {input1, input2, cmd_valid, busy});
            else passed++;
        end
    endtask

    task automatic test_chord;
        logic [2:0] exp;
        int pulses;
        pulses   = 0;
        btn1_raw = 1'b1;
        tick();
        btn2_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (cmd_valid === 1'b1) pulses++;
            exp = (k == 8) ? 3'b111 : 3'b000;
            checks++;
            if ({input1, input2, cmd_valid} !== exp)
                $display("FAIL chord k=%0d cmd=%b exp=%b", k, {input1, input2, cmd_valid}, exp);
            else passed++;
        end
        checks++;
        if (pulses !== 1) $display("FAIL chord_count got=%0d exp=1", pulses);
        else passed++;
        btn1_raw = 1'b0;
        btn2_raw = 1'b0;
        wait_idle("chord");
    endtask

    task automatic test_autorepeat;
        logic [2:0] exp;
        logic       hit;
        int pulses;
        int exp_pulses;
        pulses   = 0;
        btn2_raw = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (cmd_valid === 1'b1) pulses++;
`ifdef FSM_COND_AUTOREPEAT_EN
            hit = (k >= 8) && ((k - 8) % 10 == 0);
`else
            hit = (k == 8);
`endif
            exp = hit ? 3'b011 : 3'b000;
            checks++;
            if ({input1, input2, cmd_valid} !== exp)
                $display("FAIL hold k=%0d cmd=%b exp=%b", k, {input1, input2, cmd_valid}, exp);
            else passed++;
        end
`ifdef FSM_COND_AUTOREPEAT_EN
        exp_pulses = 5;
`else
        exp_pulses = 1;
`endif
        checks++;
        if (pulses !== exp_pulses) $display("FAIL hold_count got=%0d exp=%0d", pulses, exp_pulses);
        else passed++;
        btn2_raw = 1'b0;
        wait_idle("hold");
    endtask

    task automatic test_reset_mid_chord;
        btn1_raw = 1'b1;
        for (int k = 0; k <= 6; k++) tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL mid_chord_busy busy=%b exp=1", busy);
        else passed++;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({input1, input2, cmd_valid, busy} !== 4'b0000)
            $display("FAIL reset_assert out=%b exp=0000", {input1, input2, cmd_valid, busy});
        else passed++;
        tick();
        tick();
        checks++;
        if ({input1, input2, cmd_valid, busy} !== 4'b0000)
            $display("FAIL reset_hold out=%b exp=0000", {input1, input2, cmd_valid, busy});
        else passed++;
        reset_n = 1'b1;
        tick();
        tick();
        btn1_raw = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if ({input1, input2, cmd_valid, busy} !== 4'b0000)
                $display("FAIL after_reset k=%0d out=%b exp=0000", k, {input1, input2, cmd_valid, busy});
            else passed++;
        end
    endtask

    task automatic test_late_second;
        logic [2:0] exp;
        btn1_raw = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            tick();
            exp = (k == 8) ? 3'b101 : 3'b000;
            checks++;
            if ({input1, input2, cmd_valid} !== exp)
                $display("FAIL late_first k=%0d cmd=%b exp=%b", k, {input1, input2, cmd_valid}, exp);
            else passed++;
        end
        btn2_raw = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if ({input1, input2, cmd_valid, busy} !== 4'b0001)
                $display("FAIL late_both k=%0d out=%b exp=0001", k, {input1, input2, cmd_valid, busy});
            else passed++;
        end
        btn1_raw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({input1, input2, cmd_valid, busy} !== 4'b0001)
                $display("FAIL late_b2only k=%0d out=%b exp=0001", k, {input1, input2, cmd_valid, busy});
            else passed++;
        end
        btn2_raw = 1'b0;
        wait_idle("late_release");
        btn2_raw = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            tick();
            exp = (k == 8) ? 3'b011 : 3'b000;
            checks++;
            if ({input1, input2, cmd_valid} !== exp)
                $display("FAIL late_repress k=%0d cmd=%b exp=%b", k, {input1, input2, cmd_valid}, exp);
            else passed++;
        end
        btn2_raw = 1'b0;
        wait_idle("late_repress");
    endtask

    initial begin
        clk      = 1'b0;
        reset_n  = 1'b0;
        btn1_raw = 1'b0;
        btn2_raw = 1'b0;
        test_reset();
        test_single_press();
        test_glitch();
        test_chord();
        test_autorepeat();
        test_reset_mid_chord();
        test_late_second();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fsm_input_conditioner.md
# fsm_input_conditioner

Upstream front end for the three-state control FSM: takes two raw, asynchronous, bouncing push-button lines and produces the FSM's `input1`/`input2` command pair. Each line is synchronised and debounced. Near-simultaneous presses are merged into one chord code. Each accepted press is presented as exactly one clock of a non-zero code, so the downstream FSM advances at most one state per press. Between commands the outputs sit at code 00, which is a no-transition code in every FSM state.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive synced cycles a line must hold a new level before the debounced level changes (≥1).
- `CHORD_CYCLES`, 4: collection window, in cycles, after the first debounced press (≥1).
- `REPEAT_CYCLES`, 1000: autorepeat period while the code is held (≥2; used only with the macro).
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `btn1_raw` in 1: raw button 1, asynchronous to `clk`.
- `btn2_raw` in 1: raw button 2, asynchronous to `clk`.
- `input1` out 1: command bit 1 to the FSM, registered.
- `input2` out 1: command bit 2 to the FSM, registered.
- `cmd_valid` out 1: high exactly while `{input1,input2}` ≠ 00.
- `busy` out 1: conditioner FSM is not in IDLE.

## Operation
- Per line: 2-flop synchroniser (reset 0), then debouncer.
- Debouncer has a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Counter clears whenever synced == debounced.
  - Otherwise it increments.
  - On the edge where the counter equals `DEBOUNCE_CYCLES-1`, the debounced level toggles and the counter clears.
- `db = {db1,db2}`. Code values: 00 IDLE, 10, 01, 11.
- Conditioner FSM:
  - IDLE: if `db` ≠ 00, then `code <= db`, `timer <= 0`, go CHORD.
  - CHORD: `code <= code | db` and `timer++` each cycle; when `timer == CHORD_CYCLES-1`, go EMIT. A release inside the window still emits the captured code.
  - EMIT: lasts one cycle; go RELEASE.
  - RELEASE: when `db == 00`, go IDLE. A new press is never accepted until both lines have released.
- Outputs are registered and loaded on the edge entering EMIT: `{input1,input2} <= code`, `cmd_valid <= 1`. They return to 0 on the next edge.
- `busy` = state ≠ IDLE.
- Reset (any time, including mid-CHORD or mid-EMIT): state IDLE; code, timer, counters, synchronisers and debounced levels to 0; `input1 = input2 = cmd_valid = busy = 0`. A command that was in progress is discarded and is not emitted after reset release.

## Timing
- Latency: count the first edge that samples `btn_raw` high as edge 0. The command is visible after edge `DEBOUNCE_CYCLES + CHORD_CYCLES + 2`.
- Command width is exactly 1 cycle. No back-to-back commands without an intervening IDLE, except autorepeat.
- Bounce shorter than `DEBOUNCE_CYCLES` synced cycles is fully rejected.
- Second line debounced within the CHORD window: code 11.
- Second line debounced after the window: ignored until both lines have released.

## Configuration
- `FSM_COND_AUTOREPEAT_EN` defined:
  - In RELEASE, while `db == code`, a repeat timer counts.
  - At `REPEAT_CYCLES-1` the FSM re-enters EMIT and re-emits `code`, then restarts the timer.
  - Any change of `db` clears the repeat timer.
- Undefined: exactly one command per press; the repeat timer and parameter logic are absent.

## Structure
- Package `fsm_input_pkg`:
  - state enum `cond_state_t` {IDLE, CHORD, EMIT, RELEASE};
  - localparams `CODE_IDLE` 2'b00, `CODE_B1` 2'b10, `CODE_B2` 2'b01, `CODE_BOTH` 2'b11.
- Sub-module `input_debounce` (synchroniser + debouncer, one line, parameter `DEBOUNCE_CYCLES`), instantiated twice.
- The top level contains the chord/emit FSM and the output registers.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=4`, `CHORD_CYCLES=2`, `REPEAT_CYCLES=10`.
- `btn1_raw` 0→1 sampled at edge 0 and held → `input1=1`, `input2=0`, `cmd_valid=1` after edge 8 for one cycle, then 00; `busy` stays 1 until release.
- `btn1_raw` glitch high for 3 cycles → `input1`, `input2`, `cmd_valid` and `busy` all remain 0.
- `btn1_raw` high, `btn2_raw` high 1 cycle later, both held → single command `{1,1}`; neither `{1,0}` nor `{0,1}` ever appears.
- `btn2` held 50 cycles → macro off: exactly one `{0,1}` pulse; macro on: first pulse, then one pulse every 10 cycles while held.
- Press `btn1`, assert `reset_n=0` while `busy=1` in CHORD, then release reset with `btn1` still held → all outputs 0 during reset, no command emitted for that press afterward.
- `btn1` held, then `btn2` pressed after the window while `btn1` is still held → no second command until both are released and `btn2` is pressed again, which gives `{0,1}`.
